// File: rtl/datapath_seq_pkg.sv
// ---------------------------------------------------------------------------
// dp_seq_pkg : sequencer states and ALU/shift/writeback-select encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/datapath_seq_regfile.sv
// ---------------------------------------------------------------------------
// regfile_param : NREG x WIDTH register file, sync write, two comb read ports
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_param #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [RW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RW-1:0]    raddr_a_i,
  input  logic [RW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/datapath_seq.sv
// ---------------------------------------------------------------------------
// datapath_seq : register file + A/B/C operands + shifter/ALU + status with
// an internal RDA/RDB/EXEC/WB sequencer behind a valid/ready handshake.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module datapath_seq
  import dp_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  parameter  int PCW   = 8,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [RW-1:0]    req_rn,
  input  logic [RW-1:0]    req_rm,
  input  logic [RW-1:0]    req_rd,
  input  logic [1:0]       req_aluop,
  input  logic [1:0]       req_shift,
  input  logic             req_asel,
  input  logic             req_bsel,
  input  logic [1:0]       req_vsel,
  input  logic             req_write,
  input  logic             req_loads,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   PC,
  output logic [WIDTH-1:0] datapath_out,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             done
);

  typedef struct packed {
    logic [RW-1:0]    rn;
    logic [RW-1:0]    rm;
    logic [RW-1:0]    rd;
    logic [1:0]       aluop;
    logic [1:0]       shift;
    logic             asel;
    logic             bsel;
    logic [1:0]       vsel;
    logic             write;
    logic             loads;
    logic [WIDTH-1:0] imm8;
    logic [WIDTH-1:0] imm5;
    logic [PCW-1:0]   pc;
  } op_t;

  function automatic logic [WIDTH-1:0] shift_f(input logic [1:0] sh, input logic [WIDTH-1:0] b);
    case (sh)
      SH_LSL:  return {b[WIDTH-2:0], 1'b0};
      SH_LSR:  return {1'b0, b[WIDTH-1:1]};
      SH_ASR:  return {b[WIDTH-1], b[WIDTH-1:1]};
      default: return b;
    endcase
  endfunction

  // Returns {overflow, result}; overflow is only meaningful for ADD/SUB.
  function automatic logic [WIDTH:0] alu_f(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r = a & b;
      default: r = ~b;
    endcase
    return {v, r};
  endfunction

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             n_q, v_q, z_q, done_q;

  logic [WIDTH-1:0] rdata_a, rdata_b, ain, bin, wb_data, pc_ext;
  logic [WIDTH:0]   alu_res;
  logic             wb_en;

  regfile_param #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wb_en),
    .waddr_i   (op_q.rd),
    .wdata_i   (wb_data),
    .raddr_a_i (op_q.rn),
    .raddr_b_i (op_q.rm),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = '{rn: req_rn, rm: req_rm, rd: req_rd, aluop: req_aluop, shift: req_shift,
                      asel: req_asel, bsel: req_bsel, vsel: req_vsel, write: req_write,
                      loads: req_loads, imm8: sximm8, imm5: sximm5, pc: PC};
          state_d = RDA;
        end
      end
      RDA:     state_d = RDB;
      RDB:     state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ain     = op_q.asel ? '0 : a_q;
    bin     = op_q.bsel ? op_q.imm5 : shift_f(op_q.shift, b_q);
    alu_res = alu_f(op_q.aluop, ain, bin);
    pc_ext  = '0;
    pc_ext[PCW-1:0] = op_q.pc;
    case (op_q.vsel)
      VSEL_PC:    wb_data = pc_ext;
      VSEL_IMM8:  wb_data = op_q.imm8;
      VSEL_MDATA: wb_data = mdata;
      default:    wb_data = c_q;
    endcase
    wb_en = (state_q == WB) && op_q.write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= (state_q == WB);
      if (state_q == RDA) a_q <= rdata_a;
      if (state_q == RDB) b_q <= rdata_b;
      if (state_q == EXEC) begin
        c_q <= alu_res[WIDTH-1:0];
        if (op_q.loads) begin
          n_q <= alu_res[WIDTH-1];
          v_q <= alu_res[WIDTH];
          z_q <= (alu_res[WIDTH-1:0] == '0);
        end
      end
    end
  end

  assign datapath_out = c_q;
  assign N            = n_q;
  assign V            = v_q;
  assign Z            = z_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_seq.sv
// ---------------------------------------------------------------------------
// tb_datapath_seq : directed vector table plus busy/abort sequences on a
// 16-bit/8-register and a 32-bit/16-register instance.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_datapath_seq;

  typedef struct {
    logic [3:0]  rn, rm, rd;
    logic [1:0]  aluop, shift, vsel;
    logic        asel, bsel, write, loads;
    logic [31:0] imm8, imm5, mdata;
    logic [7:0]  pc;
    logic [31:0] exp_out;
    logic [2:0]  exp_nvz;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, valid0, valid1, sel;
  logic [3:0]  rn, rm, rd;
  logic [1:0]  aluop, shift, vsel;
  logic        asel, bsel, wr, loads;
  logic [31:0] imm8, imm5, mdata;
  logic [7:0]  pc;

  logic        rdy0, rdy1, done0, done1, n0, v0, z0, n1, v1, z1;
  logic [15:0] out0;
  logic [31:0] out1;

  logic [31:0] s_out;
  logic [2:0]  s_nvz;
  logic        s_done, s_ready;

  assign s_out   = sel ? out1 : {16'h0, out0};
  assign s_nvz   = sel ? {n1, v1, z1} : {n0, v0, z0};
  assign s_done  = sel ? done1 : done0;
  assign s_ready = sel ? rdy1 : rdy0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  datapath_seq #(.WIDTH(16), .NREG(8), .PCW(8)) u_dut0 (
    .clk(clk), .reset(rst0), .req_valid(valid0), .req_ready(rdy0),
    .req_rn(rn[2:0]), .req_rm(rm[2:0]), .req_rd(rd[2:0]),
    .req_aluop(aluop), .req_shift(shift), .req_asel(asel), .req_bsel(bsel),
    .req_vsel(vsel), .req_write(wr), .req_loads(loads),
    .sximm8(imm8[15:0]), .sximm5(imm5[15:0]), .mdata(mdata[15:0]), .PC(pc),
    .datapath_out(out0), .N(n0), .V(v0), .Z(z0), .done(done0)
  );

  datapath_seq #(.WIDTH(32), .NREG(16), .PCW(8)) u_dut1 (
    .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(rdy1),
    .req_rn(rn), .req_rm(rm), .req_rd(rd),
    .req_aluop(aluop), .req_shift(shift), .req_asel(asel), .req_bsel(bsel),
    .req_vsel(vsel), .req_write(wr), .req_loads(loads),
    .sximm8(imm8), .sximm5(imm5), .mdata(mdata), .PC(pc),
    .datapath_out(out1), .N(n1), .V(v1), .Z(z1), .done(done1)
  );

  // Unselected writeback sources carry distinct junk so a wrong vsel decode shows.
  function automatic vec_t mk(input logic [3:0] i_rn, i_rm, i_rd, input logic [1:0] i_op, i_sh,
                              input logic i_asel, i_bsel, input logic [1:0] i_vsel,
                              input logic i_wr, i_ld, input logic [31:0] i_imm,
                              input logic [31:0] i_exp, input logic [2:0] i_nvz);
    vec_t v;
    v.rn = i_rn; v.rm = i_rm; v.rd = i_rd; v.aluop = i_op; v.shift = i_sh;
    v.asel = i_asel; v.bsel = i_bsel; v.vsel = i_vsel; v.write = i_wr; v.loads = i_ld;
    v.imm5  = i_imm;
    v.imm8  = (i_vsel == 2'b10) ? i_imm : 32'h0000_0333;
    v.mdata = (i_vsel == 2'b11) ? i_imm : 32'h0000_0444;
    v.pc    = (i_vsel == 2'b01) ? i_imm[7:0] : 8'h55;
    v.exp_out = i_exp; v.exp_nvz = i_nvz;
    return v;
  endfunction

  // Read register r through the datapath: C = 0 + R[r], no write, no status.
  function automatic vec_t rd_reg(input logic [3:0] r, input logic [31:0] e, input logic [2:0] nvz);
    return mk(4'd0, r, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, e, nvz);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input vec_t v);
    rn = v.rn; rm = v.rm; rd = v.rd; aluop = v.aluop; shift = v.shift;
    asel = v.asel; bsel = v.bsel; vsel = v.vsel; wr = v.write; loads = v.loads;
    imm8 = v.imm8; imm5 = v.imm5; mdata = v.mdata; pc = v.pc;
  endtask

  task automatic scramble();
    rn = ~rn; rm = ~rm; rd = ~rd; aluop = ~aluop; shift = ~shift; asel = ~asel; bsel = ~bsel;
    vsel = ~vsel; wr = ~wr; loads = ~loads; imm8 = ~imm8; imm5 = ~imm5; mdata = ~mdata; pc = ~pc;
  endtask

  task automatic set_valid(input logic b);
    if (sel) valid1 = b; else valid0 = b;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int  n;
    bit  got, rdy_low;
    @(negedge clk);
    chk({nm, " ready"}, {31'h0, s_ready}, 32'h1);
    drive(v);
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    scramble();
    n = 0; got = 0; rdy_low = 1;
    while (!got && n < 8) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 3) mdata = v.mdata;
      if (s_done) got = 1;
      else if (s_ready) rdy_low = 0;
    end
    chk({nm, " latency"}, n, 4);
    chk({nm, " busy"}, {31'h0, rdy_low}, 32'h1);
    chk({nm, " out"}, s_out, v.exp_out);
    chk({nm, " nvz"}, {29'h0, s_nvz}, {29'h0, v.exp_nvz});
  endtask

  task automatic abort_op(input vec_t v, input string nm);
    int nd;
    nd = 0;
    @(negedge clk);
    drive(v);
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      if (s_done) nd++;
    end
    if (sel) rst1 = 1'b1; else rst0 = 1'b1;
    #1;
    chk({nm, " async out"}, s_out, 32'h0);
    chk({nm, " async nvz"}, {29'h0, s_nvz}, 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      if (s_done) nd++;
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (s_done) nd++;
    end
    chk({nm, " no done"}, nd, 0);
    chk({nm, " ready"}, {31'h0, s_ready}, 32'h1);
    chk({nm, " nvz"}, {29'h0, s_nvz}, 32'h0);
  endtask

  task automatic busy_test();
    vec_t va, vb;
    int   nd, d1, d2;
    logic [31:0] oa, ob;
    va = rd_reg(4'd0, 32'h0, 3'b0);
    vb = rd_reg(4'd3, 32'h0, 3'b0);
    nd = 0; d1 = -1; d2 = -1; oa = '0; ob = '0;
    @(negedge clk);
    drive(va);
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        drive(vb);
        valid0 = 1'b1;
      end
      if (n == 5) valid0 = 1'b0;
      if (done0) begin
        nd++;
        if (nd == 1) begin d1 = n; oa = s_out; end
        else begin d2 = n; ob = s_out; end
      end
    end
    chk("busy done count", nd, 2);
    chk("busy first done", d1, 4);
    chk("busy second done", d2, 9);
    chk("busy first out", oa, 32'h8000);
    chk("busy second out", ob, 32'h7FFF);
  endtask

  vec_t tab0[22];
  vec_t tab1[6];

  initial begin
    sel = 0; valid0 = 0; valid1 = 0; rst0 = 1; rst1 = 1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //             rn rm rd op sh as bs vs wr ld imm            exp            nvz
    tab0[0]  = mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 32'h7,        32'h0,         3'b000);
    tab0[1]  = rd_reg(0, 32'h7, 3'b000);
    tab0[2]  = mk(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 32'h2,        32'hE,         3'b000);
    tab0[3]  = mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h9,         3'b000);
    tab0[4]  = rd_reg(2, 32'h9, 3'b000);
    tab0[5]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 32'h8000,     32'hE,         3'b000);
    tab0[6]  = mk(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 32'h1,        32'h0,         3'b000);
    tab0[7]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 1, 32'h0,        32'h7FFF,      3'b010);
    tab0[8]  = rd_reg(3, 32'h7FFF, 3'b010);
    tab0[9]  = mk(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 32'h8004,     32'h0,         3'b010);
    tab0[10] = mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0,        32'hC002,      3'b010);
    tab0[11] = mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 32'h0,        32'h4002,      3'b010);
    tab0[12] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0008,      3'b010);
    tab0[13] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         3'b001);
    tab0[14] = mk(1, 3, 0, 2, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0004,      3'b000);
    tab0[15] = mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 32'h0,        32'h8000,      3'b100);
    tab0[16] = mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFF0,     32'hFFF9,      3'b100);
    tab0[17] = mk(0, 0, 4, 0, 0, 0, 0, 1, 1, 0, 32'hA5,       32'h0,         3'b100);
    tab0[18] = rd_reg(4, 32'h00A5, 3'b100);
    tab0[19] = mk(3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'hFFFE,      3'b110);
    tab0[20] = mk(2, 2, 2, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h12,        3'b110);
    tab0[21] = rd_reg(2, 32'h12, 3'b110);

    tab1[0]  = mk(0, 0, 14, 0, 0, 0, 0, 2, 1, 0, 32'h7FFFFFFF, 32'h0,        3'b000);
    tab1[1]  = mk(14, 14, 15, 0, 0, 0, 0, 0, 1, 1, 32'h0,     32'hFFFFFFFE,  3'b110);
    tab1[2]  = rd_reg(15, 32'hFFFFFFFE, 3'b110);
    tab1[3]  = mk(0, 15, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0,       32'hFFFFFFFF,  3'b110);
    tab1[4]  = mk(0, 0, 13, 0, 0, 0, 0, 1, 1, 0, 32'hA5,      32'h0,         3'b110);
    tab1[5]  = rd_reg(13, 32'h000000A5, 3'b110);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 0; rst1 = 0;
    #1;
    chk("rst0 ready", {31'h0, rdy0}, 32'h1);
    chk("rst0 out", {16'h0, out0}, 32'h0);
    chk("rst0 nvz", {29'h0, n0, v0, z0}, 32'h0);
    chk("rst0 done", {31'h0, done0}, 32'h0);
    chk("rst1 ready", {31'h0, rdy1}, 32'h1);
    chk("rst1 out", out1, 32'h0);
    chk("rst1 nvz", {29'h0, n1, v1, z1}, 32'h0);
    chk("rst1 done", {31'h0, done1}, 32'h0);

    sel = 0;
    for (int i = 0; i < 22; i++) run_op(tab0[i], $sformatf("w16 v%0d", i));
    busy_test();
    abort_op(mk(3, 3, 5, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 3'b0), "w16 abort");
    run_op(rd_reg(5, 32'h0, 3'b000), "w16 post-abort r5");

    sel = 1;
    for (int i = 0; i < 6; i++) run_op(tab1[i], $sformatf("w32 v%0d", i));
    abort_op(mk(14, 14, 15, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 3'b0), "w32 abort");
    run_op(rd_reg(15, 32'h0, 3'b000), "w32 post-abort r15");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
